i2c_txn_arbiter: RTL
====================

Name: i2c_txn_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares one i2c_master datapath between N_REQ requesters. It latches each granted requester's command (slave address, register address, rw, write data) and launches it on the master. It retries NACKed transfers and enforces a watchdog timeout. Completion status and read data are returned to the owning requester. It sits between on-chip clients (sensor pollers, config loaders) and the I2C master.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 1024, max cycles from m_start to m_done before abort (>=4)
MAX_RETRY, 2, extra attempts after a NACK (0..7)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester request, held until its done/err
req_slave_addr  input  7*N_REQ  packed 7-bit slave addresses, slice i = requester i
req_reg_addr  input  7*N_REQ  packed 7-bit register addresses
req_rw  input  N_REQ  1 = write, 0 = read (same convention as i2c_master)
req_wdata  input  8*N_REQ  packed write bytes
gnt  output  N_REQ  one-hot owner, high from latch until completion
done  output  N_REQ  1-cycle pulse to owner on completion (success or fail)
err  output  N_REQ  1-cycle pulse with done when the transaction failed
rdata  output  8  read byte, valid in the done cycle; 0 for writes/failures
m_start  output  1  1-cycle launch pulse to master
m_slave_addr  output  7  latched command to master
m_reg_addr  output  7  latched command to master
m_rw  output  1  latched command to master
m_wdata  output  8  latched command to master
m_busy  input  1  master mid-transaction
m_done  input  1  1-cycle pulse, master finished
m_ack_err  input  1  valid with m_done: slave NACKed
m_rdata  input  8  valid with m_done on reads

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, retry=0, timer=0. gnt, done, err, m_start = 0. rdata, m_* command = 0. An in-flight transaction is abandoned with no done.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT, COMPLETE.
- IDLE:
  - If any req bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Latch its command slices into m_*, set gnt[idx], clear retry and timer, go LAUNCH.
  - No req: stay in IDLE.
- LAUNCH:
  - If m_busy=0, pulse m_start for exactly one cycle, go WAIT.
  - Else hold in LAUNCH.
  - timer increments every cycle in LAUNCH and WAIT.
- WAIT:
  - m_done && !m_ack_err: capture rdata = m_rw ? 0 : m_rdata, success, go COMPLETE.
  - m_done && m_ack_err && retry<MAX_RETRY: retry++, timer=0, go LAUNCH. Command is unchanged.
  - m_done && m_ack_err && retry==MAX_RETRY: fail, go COMPLETE.
  - timer==TIMEOUT-1 without m_done: fail, go COMPLETE.
  - If m_done and timeout occur in the same cycle, m_done wins.
- COMPLETE (one cycle):
  - Pulse done[idx], plus err[idx] on fail. On fail rdata=0.
  - Clear gnt. rr_ptr=(idx+1) mod N_REQ. Go IDLE.
- Latency: req seen in IDLE at cycle 0 -> gnt and LAUNCH at 1 -> m_start at 1 (m_busy low) -> m_done sampled at k -> done at k+1 -> next arbitration at k+2.
- req is not sampled outside IDLE. A requester dropping req mid-transaction does not abort it; done is still pulsed.
- Commands change only at latch. Input changes during a transaction are ignored.
- Requesters must clear req in the cycle after done, or they are re-arbitrated behind the others.
- m_done outside WAIT is ignored. rdata holds its value until the next COMPLETE.

Test Plan:
- Single write: req[0], slave 0x50, reg 0x12, rw=1, wdata 0xA5; master model done after 20 cycles, no NACK -> gnt[0] at cycle 1, one m_start with m_* = 0x50/0x12/1/0xA5, done[0] at 22, err=0, rdata=0.
- Read: req[2], rw=0; m_rdata=0x3C with m_done -> done[2] with rdata=0x3C, err[2]=0.
- Round-robin: req=4'b1111 held, each transaction 10 cycles, requesters release after done -> grant order 0,1,2,3,0; no gnt overlap; exactly one m_start per grant.
- NACK retry: MAX_RETRY=2, master NACKs twice then ACKs -> 3 m_start pulses, done without err. NACKs all 3 times -> done and err after the 3rd m_done, rdata=0.
- Timeout: TIMEOUT=16, master never asserts m_done -> done[idx] and err[idx] 16 cycles after LAUNCH entry, gnt cleared, next requester served.
- Reset mid-WAIT: assert rst asynchronously -> gnt/m_start/done/err 0 immediately with no done pulse. After release with req[3] pending -> served first (rr_ptr=0 scan: 0,1,2 idle).

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin arbiter and transaction sequencer sharing one i2c_master
// Latches the granted requester's command, launches it, retries NACKs and enforces a watchdog.
module i2c_txn_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [7*N_REQ-1:0] req_slave_addr,
  input  logic [7*N_REQ-1:0] req_reg_addr,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic [7:0]         rdata,
  output logic               m_start,
  output logic [6:0]         m_slave_addr,
  output logic [6:0]         m_reg_addr,
  output logic               m_rw,
  output logic [7:0]         m_wdata,
  input  logic               m_busy,
  input  logic               m_done,
  input  logic               m_ack_err,
  input  logic [7:0]         m_rdata
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LAUNCH   = 2'd1;
  localparam logic [1:0] S_WAIT     = 2'd2;
  localparam logic [1:0] S_COMPLETE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d, idx_q, idx_d;
  logic [2:0]       retry_q, retry_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             m_start_q, m_start_d;
  logic [6:0]       sa_q, sa_d, ra_q, ra_d;
  logic             rw_q, rw_d;
  logic [7:0]       wd_q, wd_d;

  logic [6:0] sa_arr [N_REQ];
  logic [6:0] ra_arr [N_REQ];
  logic [7:0] wd_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign sa_arr[g] = req_slave_addr[7*g +: 7];
    assign ra_arr[g] = req_reg_addr[7*g +: 7];
    assign wd_arr[g] = req_wdata[8*g +: 8];
  end

  // Rotate req so bit 0 is the rr_ptr position; the lowest set bit is then the winner.
  logic [2*N_REQ-1:0] req2;
  logic [N_REQ-1:0]   rot;
  logic [IW-1:0]      off, pick;
  logic [IW:0]        sum;
  logic               found;

  assign req2 = {req, req} >> rr_q;
  assign rot  = req2[N_REQ-1:0];

  always_comb begin
    off   = '0;
    found = |rot;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum  = {1'b0, rr_q} + {1'b0, off};
    pick = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    m_start_d = 1'b0;
    sa_d      = sa_q;
    ra_d      = ra_q;
    rw_d      = rw_q;
    wd_d      = wd_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d     = pick;
          sa_d      = sa_arr[pick];
          ra_d      = ra_arr[pick];
          rw_d      = req_rw[pick];
          wd_d      = wd_arr[pick];
          gnt_d     = N_REQ'(1) << pick;
          retry_d   = '0;
          timer_d   = '0;
          m_start_d = !m_busy;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // m_start is raised on entry when the master is free, so LAUNCH waits until it has been seen.
        timer_d = timer_q + TW'(1);
        if (m_start_q) state_d = S_WAIT;
        else if (!m_busy) m_start_d = 1'b1;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (m_done && !m_ack_err) begin
          rdata_d = rw_q ? 8'h00 : m_rdata;
          done_d  = N_REQ'(1) << idx_q;
          state_d = S_COMPLETE;
        end else if (m_done && (retry_q < 3'(MAX_RETRY))) begin
          retry_d   = retry_q + 3'd1;
          timer_d   = '0;
          m_start_d = !m_busy;
          state_d   = S_LAUNCH;
        end else if (m_done || (timer_q == TW'(TIMEOUT - 1))) begin
          rdata_d = 8'h00;
          done_d  = N_REQ'(1) << idx_q;
          err_d   = N_REQ'(1) << idx_q;
          state_d = S_COMPLETE;
        end
      end
      default: begin
        gnt_d   = '0;
        rr_d    = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      m_start_q <= 1'b0;
      sa_q      <= '0;
      ra_q      <= '0;
      rw_q      <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      m_start_q <= m_start_d;
      sa_q      <= sa_d;
      ra_q      <= ra_d;
      rw_q      <= rw_d;
      wd_q      <= wd_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign m_start      = m_start_q;
  assign m_slave_addr = sa_q;
  assign m_reg_addr   = ra_q;
  assign m_rw         = rw_q;
  assign m_wdata      = wd_q;

endmodule
